// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bus bundle for the execute stage.
// master drives the ID/EX side; slave is the execute stage itself.
interface ex_stage_if;
  logic        Valid_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        ALUSrc_i;
  logic        RegDst_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic [31:0] Imm_i;
  logic [4:0]  Rs_i;
  logic [4:0]  Rt_i;
  logic        Stall_o;
  logic        Valid_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic [31:0] ALUResult_o;
  logic [31:0] WriteData_o;
  logic [4:0]  WriteReg_o;
  logic        Zero_o;

  modport master (
    output Valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, RegDst_i, ALUOp_i, RSdata_i, RTdata_i, Imm_i, Rs_i, Rt_i,
    input  Stall_o, Valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
           ALUResult_o, WriteData_o, WriteReg_o, Zero_o
  );

  modport slave (
    input  Valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, RegDst_i, ALUOp_i, RSdata_i, RTdata_i, Imm_i, Rs_i, Rt_i,
    output Stall_o, Valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
           ALUResult_o, WriteData_o, WriteReg_o, Zero_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step iterative shift-add multiplier
// that stalls the upstream pipeline while it runs.
module ex_stage #(
  parameter bit MUL_EN = 1'b1
) (
  input logic       Clk,
  input logic       Rst,
  ex_stage_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned FW = 6;

  localparam logic [FW-1:0] F_ADD = 6'h20;
  localparam logic [FW-1:0] F_SUB = 6'h22;
  localparam logic [FW-1:0] F_AND = 6'h24;
  localparam logic [FW-1:0] F_OR  = 6'h25;
  localparam logic [FW-1:0] F_SLT = 6'h2A;
  localparam logic [FW-1:0] F_MUL = 6'h18;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;

  // MUL's own control/destination, captured at acceptance
  logic          m_reg_write_q, m_reg_write_d;
  logic          m_mem_to_reg_q, m_mem_to_reg_d;
  logic          m_mem_read_q, m_mem_read_d;
  logic          m_mem_write_q, m_mem_write_d;
  logic [DW-1:0] m_write_data_q, m_write_data_d;
  logic [RW-1:0] m_write_reg_q, m_write_reg_d;

  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [RW-1:0] write_reg_q, write_reg_d;
  logic          zero_q, zero_d;

  logic          stall_c;
  logic [DW-1:0] op_b_c;
  logic [FW-1:0] funct_c;
  logic [DW-1:0] alu_c;
  logic [RW-1:0] dest_c;
  logic          is_mul_c;
  logic [DW-1:0] acc_step_c;
  logic          unused_rs_c;

  assign unused_rs_c = ^bus.Rs_i;

  // Single-cycle ALU and operand/destination selection
  always_comb begin
    op_b_c   = bus.ALUSrc_i ? bus.Imm_i : bus.RTdata_i;
    funct_c  = bus.Imm_i[FW-1:0];
    dest_c   = bus.RegDst_i ? bus.Imm_i[15:11] : bus.Rt_i;
    is_mul_c = MUL_EN && bus.Valid_i && (bus.ALUOp_i == 2'b10) && (funct_c == F_MUL);
    alu_c    = '0;
    unique case (bus.ALUOp_i)
      2'b01: alu_c = bus.RSdata_i - op_b_c;
      2'b10: begin
        unique case (funct_c)
          F_ADD:   alu_c = bus.RSdata_i + op_b_c;
          F_SUB:   alu_c = bus.RSdata_i - op_b_c;
          F_AND:   alu_c = bus.RSdata_i & op_b_c;
          F_OR:    alu_c = bus.RSdata_i | op_b_c;
          F_SLT:   alu_c = DW'($signed(bus.RSdata_i) < $signed(op_b_c));
          default: alu_c = '0;
        endcase
      end
      default: alu_c = bus.RSdata_i + op_b_c;
    endcase
  end

  assign acc_step_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state, multiplier datapath and output-stage load values
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    m_reg_write_d  = m_reg_write_q;
    m_mem_to_reg_d = m_mem_to_reg_q;
    m_mem_read_d   = m_mem_read_q;
    m_mem_write_d  = m_mem_write_q;
    m_write_data_d = m_write_data_q;
    m_write_reg_d  = m_write_reg_q;
    stall_c        = 1'b0;

    valid_d        = bus.Valid_i;
    reg_write_d    = bus.Valid_i & bus.RegWrite_i;
    mem_to_reg_d   = bus.MemtoReg_i;
    mem_read_d     = bus.Valid_i & bus.MemRead_i;
    mem_write_d    = bus.Valid_i & bus.MemWrite_i;
    alu_result_d   = alu_c;
    write_data_d   = bus.RTdata_i;
    write_reg_d    = dest_c;

    unique case (state_q)
      IDLE: begin
        if (is_mul_c) begin
          stall_c        = 1'b1;
          state_d        = BUSY;
          cnt_d          = '0;
          acc_d          = '0;
          mcand_d        = bus.RSdata_i;
          mplier_d       = op_b_c;
          m_reg_write_d  = bus.RegWrite_i;
          m_mem_to_reg_d = bus.MemtoReg_i;
          m_mem_read_d   = bus.MemRead_i;
          m_mem_write_d  = bus.MemWrite_i;
          m_write_data_d = bus.RTdata_i;
          m_write_reg_d  = dest_c;
          valid_d        = 1'b0;
          reg_write_d    = 1'b0;
          mem_read_d     = 1'b0;
          mem_write_d    = 1'b0;
        end
      end
      BUSY: begin
        acc_d    = acc_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + RW'(1);
        if (&cnt_q) begin
          state_d      = IDLE;
          valid_d      = 1'b1;
          reg_write_d  = m_reg_write_q;
          mem_to_reg_d = m_mem_to_reg_q;
          mem_read_d   = m_mem_read_q;
          mem_write_d  = m_mem_write_q;
          alu_result_d = acc_step_c;
          write_data_d = m_write_data_q;
          write_reg_d  = m_write_reg_q;
        end else begin
          stall_c     = 1'b1;
          valid_d     = 1'b0;
          reg_write_d = 1'b0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    zero_d = (alu_result_d == '0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      m_reg_write_q  <= 1'b0;
      m_mem_to_reg_q <= 1'b0;
      m_mem_read_q   <= 1'b0;
      m_mem_write_q  <= 1'b0;
      m_write_data_q <= '0;
      m_write_reg_q  <= '0;
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      alu_result_q   <= '0;
      write_data_q   <= '0;
      write_reg_q    <= '0;
      zero_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      m_reg_write_q  <= m_reg_write_d;
      m_mem_to_reg_q <= m_mem_to_reg_d;
      m_mem_read_q   <= m_mem_read_d;
      m_mem_write_q  <= m_mem_write_d;
      m_write_data_q <= m_write_data_d;
      m_write_reg_q  <= m_write_reg_d;
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      alu_result_q   <= alu_result_d;
      write_data_q   <= write_data_d;
      write_reg_q    <= write_reg_d;
      zero_q         <= zero_d;
    end
  end

  // Stall is forced low during reset so upstream never freezes on an abandoned MUL
  assign bus.Stall_o     = stall_c & ~Rst;
  assign bus.Valid_o     = valid_q;
  assign bus.RegWrite_o  = reg_write_q;
  assign bus.MemtoReg_o  = mem_to_reg_q;
  assign bus.MemRead_o   = mem_read_q;
  assign bus.MemWrite_o  = mem_write_q;
  assign bus.ALUResult_o = alu_result_q;
  assign bus.WriteData_o = write_data_q;
  assign bus.WriteReg_o  = write_reg_q;
  assign bus.Zero_o      = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, bubbles, MUL stall window and reset abort.
module tb_ex_stage;
  logic clk;
  logic rst;
  int   vectors;
  int   errs;
  logic seen_valid;

  ex_stage_if bus ();

  ex_stage #(.MUL_EN(1'b1)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rw, input logic m2r, input logic mr,
                     input logic mw, input logic src, input logic dst, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                     input logic [4:0] rt);
    bus.Valid_i    = v;
    bus.RegWrite_i = rw;
    bus.MemtoReg_i = m2r;
    bus.MemRead_i  = mr;
    bus.MemWrite_i = mw;
    bus.ALUSrc_i   = src;
    bus.RegDst_i   = dst;
    bus.ALUOp_i    = op;
    bus.RSdata_i   = a;
    bus.RTdata_i   = b;
    bus.Imm_i      = imm;
    bus.Rs_i       = a[4:0];
    bus.Rt_i       = rt;
  endtask

  initial begin
    vectors    = 0;
    errs       = 0;
    seen_valid = 1'b0;
    rst        = 1'b1;
    // MUL presented during reset must not stall
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd7, 32'd9, 32'h0000_2018, 5'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.Stall_o), 32'd0);
    chk("rst_valid", 32'(bus.Valid_o), 32'd0);
    chk("rst_result", bus.ALUResult_o, 32'd0);
    chk("rst_wreg", 32'(bus.WriteReg_o), 32'd0);
    chk("rst_ctl", 32'({bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o, bus.Zero_o}), 32'd0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("idle_stall", 32'(bus.Stall_o), 32'd0);
    chk("idle_wdata", bus.WriteData_o, 32'd0);

    // add 6+7 -> rd 4
    @(negedge clk);
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd6, 32'd7, 32'h0000_2020, 5'd9);
    #1 chk("add_stall", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    chk("add_result", bus.ALUResult_o, 32'd13);
    chk("add_wreg", 32'(bus.WriteReg_o), 32'd4);
    chk("add_valid", 32'(bus.Valid_o), 32'd1);
    chk("add_zero", 32'(bus.Zero_o), 32'd0);
    chk("add_regwrite", 32'(bus.RegWrite_o), 32'd1);
    // sub 6-7
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd6, 32'd7, 32'h0000_2022, 5'd9);
    @(negedge clk);
    chk("sub_result", bus.ALUResult_o, 32'hFFFF_FFFF);
    chk("sub_zero", 32'(bus.Zero_o), 32'd0);
    // sub 7-7 via ALUOp 01
    drv(1, 1, 0, 0, 0, 0, 1, 2'b01, 32'd7, 32'd7, 32'h0000_2000, 5'd9);
    @(negedge clk);
    chk("sub0_result", bus.ALUResult_o, 32'd0);
    chk("sub0_zero", 32'(bus.Zero_o), 32'd1);
    // slt -1 < 1
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0000_202A, 5'd9);
    @(negedge clk);
    chk("slt_neg", bus.ALUResult_o, 32'd1);
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd1, 32'hFFFF_FFFF, 32'h0000_202A, 5'd9);
    @(negedge clk);
    chk("slt_pos", bus.ALUResult_o, 32'd0);
    chk("slt_pos_zero", 32'(bus.Zero_o), 32'd1);
    // and / or
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_3024, 5'd9);
    @(negedge clk);
    chk("and_result", bus.ALUResult_o, 32'h0000_F000);
    chk("and_wreg", 32'(bus.WriteReg_o), 32'd6);
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_3025, 5'd9);
    @(negedge clk);
    chk("or_result", bus.ALUResult_o, 32'h0000_FFF0);
    // unknown funct: result 0, control passes
    drv(1, 1, 1, 0, 0, 0, 1, 2'b10, 32'd5, 32'd3, 32'h0000_2027, 5'd9);
    @(negedge clk);
    chk("unk_result", bus.ALUResult_o, 32'd0);
    chk("unk_ctl", 32'({bus.Valid_o, bus.RegWrite_o, bus.MemtoReg_o}), 32'b111);
    // lw-style address
    drv(1, 1, 1, 1, 0, 1, 0, 2'b00, 32'd8, 32'h1234_5678, 32'hFFFF_FFFC, 5'd5);
    @(negedge clk);
    chk("lw_result", bus.ALUResult_o, 32'd4);
    chk("lw_wreg", 32'(bus.WriteReg_o), 32'd5);
    chk("lw_memread", 32'(bus.MemRead_o), 32'd1);
    // sw-style: store data passes through
    drv(1, 0, 0, 0, 1, 1, 0, 2'b00, 32'd100, 32'hDEAD_BEEF, 32'd20, 5'd3);
    @(negedge clk);
    chk("sw_result", bus.ALUResult_o, 32'd120);
    chk("sw_wdata", bus.WriteData_o, 32'hDEAD_BEEF);
    chk("sw_memwrite", 32'(bus.MemWrite_o), 32'd1);
    // addi 10 + (-3)
    drv(1, 1, 0, 0, 0, 1, 0, 2'b11, 32'd10, 32'd0, 32'hFFFF_FFFD, 5'd7);
    @(negedge clk);
    chk("addi_result", bus.ALUResult_o, 32'd7);
    // bubble clears valid and side-effect controls
    drv(0, 1, 0, 1, 1, 0, 1, 2'b10, 32'd6, 32'd7, 32'h0000_2020, 5'd9);
    @(negedge clk);
    chk("bubble_ctl", 32'({bus.Valid_o, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o}), 32'd0);

    // MUL 7 x 9: 32 stall cycles, result on the 33rd edge
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd7, 32'd9, 32'h0000_2018, 5'd9);
    for (int i = 0; i < 32; i++) begin
      #1 chk("mul_stall", 32'(bus.Stall_o), 32'd1);
      if (i > 0) chk("mul_bubble", 32'({bus.Valid_o, bus.RegWrite_o}), 32'd0);
      @(negedge clk);
    end
    #1 chk("mul_last_stall", 32'(bus.Stall_o), 32'd0);
    chk("mul_last_bubble", 32'(bus.Valid_o), 32'd0);
    @(negedge clk);
    chk("mul_result", bus.ALUResult_o, 32'd63);
    chk("mul_valid", 32'(bus.Valid_o), 32'd1);
    chk("mul_wreg", 32'(bus.WriteReg_o), 32'd4);
    chk("mul_regwrite", 32'(bus.RegWrite_o), 32'd1);

    // MUL 0xFFFFFFFF x 2 with an add directly behind it
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'hFFFF_FFFF, 32'd2, 32'h0000_4018, 5'd9);
    repeat (33) @(negedge clk);
    chk("mul2_result", bus.ALUResult_o, 32'hFFFF_FFFE);
    chk("mul2_wreg", 32'(bus.WriteReg_o), 32'd8);
    chk("mul2_valid", 32'(bus.Valid_o), 32'd1);
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd6, 32'd7, 32'h0000_2020, 5'd9);
    #1 chk("after_mul_stall", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    chk("after_mul_add", bus.ALUResult_o, 32'd13);
    chk("after_mul_valid", 32'(bus.Valid_o), 32'd1);

    // Reset 10 cycles into a MUL abandons it
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd3, 32'd5, 32'h0000_2018, 5'd9);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_stall_rst", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    chk("abort_valid", 32'(bus.Valid_o), 32'd0);
    chk("abort_result", bus.ALUResult_o, 32'd0);
    chk("abort_regwrite", 32'(bus.RegWrite_o), 32'd0);
    rst = 1'b0;
    drv(1, 1, 0, 0, 0, 0, 1, 2'b10, 32'd2, 32'd3, 32'h0000_2020, 5'd9);
    #1 chk("abort_idle_stall", 32'(bus.Stall_o), 32'd0);
    @(negedge clk);
    chk("abort_add_result", bus.ALUResult_o, 32'd5);
    chk("abort_add_valid", 32'(bus.Valid_o), 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Valid_o) seen_valid = 1'b1;
    end
    chk("abort_no_result", 32'(seen_valid), 32'd0);
    chk("abort_no_stall", 32'(bus.Stall_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs: decoded control bits, two register operands, sign-extended immediate, Rs/Rt numbers.
- Computes the ALU result, selects the destination register and writes its own registered EX/MEM-side outputs.
- Adds an iterative 32-cycle shift-add multiplier (MUL, funct 0x18). While MUL is in progress it raises Stall_o so IF/ID and ID/EX hold their contents.

Parameters:
MUL_EN, 1, 1 = funct 0x18 executes as MUL; 0 = funct 0x18 is treated as an unknown funct.

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous reset, active-high
Valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
RegWrite_i  in  1  control from ID/EX
MemtoReg_i  in  1  control from ID/EX
MemRead_i  in  1  control from ID/EX
MemWrite_i  in  1  control from ID/EX
ALUSrc_i  in  1  1 = operand B is Imm_i, 0 = operand B is RTdata_i
RegDst_i  in  1  1 = destination is Imm_i[15:11] (rd), 0 = destination is Rt_i
ALUOp_i  in  2  00 add, 01 sub, 10 R-type by funct, 11 add (addi)
RSdata_i  in  32  operand A
RTdata_i  in  32  register operand B / store data
Imm_i  in  32  sign-extended immediate; [5:0] = funct, [15:11] = rd
Rs_i  in  5  source register number (passed through)
Rt_i  in  5  target register number
Stall_o  out  1  combinational; hold upstream pipeline registers
Valid_o  out  1  registered; EX/MEM holds a real instruction
RegWrite_o  out  1  registered
MemtoReg_o  out  1  registered
MemRead_o  out  1  registered
MemWrite_o  out  1  registered
ALUResult_o  out  32  registered ALU or MUL result
WriteData_o  out  32  registered RTdata_i, used as store data
WriteReg_o  out  5  registered destination register number
Zero_o  out  1  registered; ALUResult == 0

Behaviour:
- Reset: every registered output is 0 and the FSM goes to IDLE. Stall_o = 0 while Rst is high.
- Reset mid-MUL: abandons the operation. No result is ever written, and outputs stay 0 for that cycle.
- Operand B = ALUSrc_i ? Imm_i : RTdata_i. All arithmetic is 32-bit two's complement; overflow wraps and no exception is raised.
- R-type funct decode:
  - 0x20 add
  - 0x22 sub
  - 0x24 and
  - 0x25 or
  - 0x2A slt (signed compare; result 1 or 0)
  - 0x18 mul (low 32 bits of the product)
  - any other funct: result 0; control bits still pass through unchanged.
- Single-cycle ops: latency 1. Inputs sampled at edge N appear on the outputs after edge N. Stall_o = 0.
- Bubble (Valid_i = 0): on the next edge, Valid_o, RegWrite_o, MemRead_o and MemWrite_o load 0. The data outputs may load any value.
- FSM has two states, IDLE and BUSY. A 5-bit counter cnt tracks MUL iterations.
- IDLE, with a valid MUL at the input (Valid_i = 1, ALUOp_i = 10, funct 0x18, MUL_EN = 1):
  - Stall_o = 1 combinationally.
  - At the edge: latch multiplicand = RSdata_i, multiplier = operand B; clear the accumulator and cnt; go to BUSY.
  - The output stage loads a bubble.
- BUSY, each edge:
  - If multiplier[0] = 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; increment cnt.
  - Stall_o = 1 while cnt < 31; the output stage loads a bubble.
- BUSY with cnt = 31:
  - Stall_o = 0.
  - At the edge: outputs load the final product (including this last step) along with the MUL's control bits, WriteReg and Valid_o = 1; go to IDLE.
  - The ID/EX register advances at the same edge, so the next instruction is seen in IDLE and the same MUL is never re-accepted.
- MUL timing: in EX for 33 cycles; Stall_o high for exactly 32 consecutive cycles; result visible 33 cycles after first presentation.
- While BUSY, the inputs are guaranteed stable because of the stall. The FSM uses its latched copies, not the live inputs.
- Zero_o is computed from the value loaded into ALUResult_o.
- Rs_i is unused internally.

Test Plan:
- Rst high for 2 cycles, then low with Valid_i = 0 -> all outputs 0, Stall_o = 0.
- R-type add: RSdata = 6, RTdata = 7, RegDst = 1, Imm[15:11] = 4, RegWrite = 1 -> next cycle ALUResult_o = 13, WriteReg_o = 4, Valid_o = 1, Zero_o = 0. Same operands with sub -> 0xFFFFFFFF; sub 7 - 7 -> Zero_o = 1.
- slt: RSdata = 0xFFFFFFFF (-1), RTdata = 1 -> 1. Swap the operands -> 0.
- lw-style: ALUOp = 00, ALUSrc = 1, RSdata = 8, Imm = 0xFFFFFFFC, RegDst = 0, Rt = 5, MemRead = 1 -> ALUResult_o = 4, WriteReg_o = 5, MemRead_o = 1.
- MUL 7 × 9 presented at cycle T -> Stall_o = 1 in cycles T..T+31 and bubbles on the outputs; from T+33 ALUResult_o = 63, Valid_o = 1. Also 0xFFFFFFFF × 2 -> 0xFFFFFFFE. An add held directly behind the MUL completes the cycle after.
- Assert Rst at cycle T+10 of a MUL -> outputs 0, Stall_o = 0, FSM IDLE. A new add after reset completes normally; the aborted MUL never produces Valid_o = 1.
